ds_op_sequencer: RTL

- Command-side initiator for the data-stack datapath. It accepts one stack macro-instruction at a time over a valid/ready handshake.
- Each instruction is expanded into a cycle-by-cycle sequence on the DSOP, ds_data and ALUOP lines. Operands and results are read back from the datapath, and the sequencer reports completion, compare status and errors.
- It sits between instruction fetch/control and the data-stack datapath. It generates the DSOP/ALUOP stimulus that the datapath consumes.

---
 rtl/ds_op_sequencer_pkg.sv | 50 +++++
 rtl/ds_depth_tracker.sv | 48 ++++
 rtl/ds_op_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ds_op_sequencer_pkg.sv
// Shared opcodes, DSOP/ALUOP encodings and FSM states for the data-stack op sequencer.
// Pure definitions: no logic, no latency, no flow control.
package ds_op_sequencer_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PUSH = 4'd1;
  localparam logic [3:0] OP_DROP = 4'd2;
  localparam logic [3:0] OP_DUP  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_CMP  = 4'd8;

  localparam logic [3:0] DSOP_IDLE  = 4'b0000;
  localparam logic [3:0] DSOP_READ  = 4'b0001;
  localparam logic [3:0] DSOP_PUSHW = 4'b0110;
  localparam logic [3:0] DSOP_POP   = 4'b1000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_CMP = 3'b100;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_READ_B,
    ST_POP_B,
    ST_GAP_B,
    ST_READ_A,
    ST_POP_A,
    ST_GAP_A,
    ST_EXEC,
    ST_ISSUE,
    ST_GAP,
    ST_DONE
  } state_t;

  function automatic logic [2:0] alu_code(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_CMP:  return ALU_CMP;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ds_depth_tracker.sv
// Stack depth counter plus per-opcode legality check; commits the depth change when an instruction completes.
// Legality is combinational on the offered opcode; the counter updates one cycle after commit_i.
module ds_depth_tracker
  import ds_op_sequencer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] op_i,
  output logic       legal_o,
  input  logic       commit_i,
  input  logic [3:0] commit_op_i
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  logic [DW-1:0] depth_q;

  always_comb begin
    legal_o = 1'b0;
    case (op_i)
      OP_NOP:                                legal_o = 1'b1;
      OP_PUSH:                               legal_o = (depth_q < FULL);
      OP_DROP:                               legal_o = (depth_q >= DW'(1));
      OP_DUP:                                legal_o = (depth_q >= DW'(1)) && (depth_q < FULL);
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_CMP: legal_o = (depth_q >= DW'(2));
      default:                               legal_o = 1'b0;
    endcase
  end

  // Binary ALU ops consume two entries and push one back; CMP pushes nothing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      depth_q <= '0;
    end else if (commit_i) begin
      case (commit_op_i)
        OP_PUSH, OP_DUP:                depth_q <= depth_q + DW'(1);
        OP_DROP, OP_ADD, OP_SUB,
        OP_AND, OP_OR:                  depth_q <= depth_q - DW'(1);
        OP_CMP:                         depth_q <= depth_q - DW'(2);
        default:                        depth_q <= depth_q;
      endcase
    end
  end

endmodule

// File: rtl/ds_op_sequencer.sv
// Expands stack macro-instructions into DSOP/ALUOP cycle sequences; 1 to 12 cycles from accept to done.
// Accepts only in IDLE (no back-to-back accept); DS_DEPTH_CHECK_EN adds depth tracking and rejection.
module ds_op_sequencer
  import ds_op_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       instr_op,
  input  logic [WIDTH-1:0] instr_imm,
  input  logic [WIDTH-1:0] ds_top,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [1:0]       alu_status,
  output logic [3:0]       DSOP,
  output logic [WIDTH-1:0] ds_data,
  output logic [2:0]       ALUOP,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             done,
  output logic             err,
  output logic [1:0]       cmp_status
);

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] opa_q, opb_q, res_q;
  logic             rej_q, issued_q, extra_q;
  logic [3:0]       dsop_q;
  logic [2:0]       aluop_q;
  logic [WIDTH-1:0] data_q, alua_q, alub_q;
  logic             done_q, err_q;
  logic [1:0]       cmp_q;

  logic             accept, depth_ok, reject, need_issue;
  logic [3:0]       issue_op;
  logic [WIDTH-1:0] issue_dat;

  assign instr_ready = (state_q == ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign reject      = (instr_op > OP_CMP) || !depth_ok;

`ifdef DS_DEPTH_CHECK_EN
  ds_depth_tracker #(.DEPTH(DEPTH)) u_depth (
    .clk         (clk),
    .reset_n     (reset_n),
    .op_i        (instr_op),
    .legal_o     (depth_ok),
    .commit_i    (done_q && !err_q),
    .commit_op_i (op_q)
  );
`else
  assign depth_ok = 1'b1;
  if (DEPTH < 1) begin : g_depth_param_check
    $error("ds_op_sequencer: DEPTH must be at least 1");
  end
`endif

  // DUP and the binary ALU ops push a value once their reads/EXEC are complete.
  assign need_issue = !issued_q && ((op_q == OP_DUP) || ((op_q >= OP_ADD) && (op_q <= OP_OR)));
  assign issue_op   = (state_q == ST_IDLE) ? instr_op : op_q;
  assign issue_dat  = (state_q == ST_IDLE) ? instr_imm : ((op_q == OP_DUP) ? opa_q : res_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (reject) begin
            state_d = ST_DONE;
          end else begin
            case (instr_op)
              OP_NOP:           state_d = ST_DONE;
              OP_PUSH, OP_DROP: state_d = ST_ISSUE;
              OP_DUP:           state_d = ST_READ_A;
              default:          state_d = ST_READ_B;
            endcase
          end
        end
      end
      ST_READ_B: state_d = ST_POP_B;
      ST_POP_B:  state_d = ST_GAP_B;
      ST_GAP_B:  state_d = ST_READ_A;
      ST_READ_A: state_d = (op_q == OP_DUP) ? ST_GAP : ST_POP_A;
      ST_POP_A:  state_d = ST_GAP_A;
      ST_GAP_A:  state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_GAP;
      ST_ISSUE:  state_d = ST_GAP;
      ST_GAP: begin
        if (extra_q)         state_d = ST_GAP;
        else if (need_issue) state_d = ST_ISSUE;
        else                 state_d = ST_DONE;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they line up with it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NOP;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      rej_q    <= 1'b0;
      issued_q <= 1'b0;
      extra_q  <= 1'b0;
      dsop_q   <= DSOP_IDLE;
      aluop_q  <= ALU_ADD;
      data_q   <= '0;
      alua_q   <= '0;
      alub_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cmp_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      dsop_q  <= DSOP_IDLE;
      aluop_q <= ALU_ADD;
      done_q  <= 1'b0;
      err_q   <= 1'b0;

      if (accept) begin
        op_q     <= instr_op;
        rej_q    <= reject;
        issued_q <= 1'b0;
      end

      case (state_q)
        ST_READ_B: opb_q <= ds_top;
        ST_READ_A: opa_q <= ds_top;
        ST_EXEC: begin
          res_q   <= alu_result;
          extra_q <= 1'b1;
          if (op_q == OP_CMP) cmp_q <= alu_status;
        end
        ST_GAP:    extra_q <= 1'b0;
        default: ;
      endcase

      case (state_d)
        ST_READ_B, ST_READ_A: dsop_q <= DSOP_READ;
        ST_POP_B, ST_POP_A:   dsop_q <= DSOP_POP;
        ST_ISSUE: begin
          issued_q <= 1'b1;
          if (issue_op == OP_DROP) begin
            dsop_q <= DSOP_POP;
          end else begin
            dsop_q <= DSOP_PUSHW;
            data_q <= issue_dat;
          end
        end
        ST_EXEC: begin
          aluop_q <= alu_code(op_q);
          alua_q  <= opa_q;
          alub_q  <= opb_q;
        end
        ST_DONE: begin
          done_q <= 1'b1;
          err_q  <= (state_q == ST_IDLE) ? reject : rej_q;
        end
        default: ;
      endcase
    end
  end

  assign DSOP       = dsop_q;
  assign ds_data    = data_q;
  assign ALUOP      = aluop_q;
  assign alu_a      = alua_q;
  assign alu_b      = alub_q;
  assign done       = done_q;
  assign err        = err_q;
  assign cmp_status = cmp_q;

endmodule
